dec_scan_ctrl: RTL and testbench

Sequencer for the 3-to-8 decoder (`my3_8`). It steps the decoder's 3-bit select through a snapshot of enabled channels, holding each channel for a programmable number of clock cycles. It runs either one pass or continuously, and flags the end of each pass. It sits between the board control logic and the decoder; `sel[2]`, `sel[1]` and `sel[0]` drive decoder inputs `a`, `b` and `c` respectively.

---
 rtl/dec_scan_pkg.sv | 10 +
 rtl/dec_scan_ctrl_next_ch_find.sv | 36 +++
 rtl/dec_scan_ctrl.sv | 91 +++++++++
 tb/tb_dec_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
package dec_scan_pkg;
   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;
endpackage

// File: rtl/dec_scan_ctrl_next_ch_find.sv
// Combinational search of an 8-bit channel mask: next above current
// (with wrap), lowest and highest enabled index.
import dec_scan_pkg::*;

module next_ch_find (
   input  logic [SEL_W-1:0] cur,
   input  logic [N_CH-1:0]  mask,
   output logic [SEL_W-1:0] nxt,
   output logic [SEL_W-1:0] low,
   output logic [SEL_W-1:0] high
);
   logic [SEL_W-1:0] idx;

   // Descending offsets so the nearest enabled channel wins; if only
   // cur itself is enabled the default keeps the select unchanged.
   always_comb begin
      nxt = cur;
      idx = '0;
      for (int i = N_CH - 1; i >= 1; i--) begin
         idx = cur + SEL_W'(i);
         if (mask[idx]) nxt = idx;
      end
   end

   always_comb begin
      low = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (mask[i]) low = SEL_W'(i);
   end

   always_comb begin
      high = '0;
      for (int i = 0; i < N_CH; i++)
         if (mask[i]) high = SEL_W'(i);
   end
endmodule

// File: rtl/dec_scan_ctrl.sv
// Steps the decoder select through a latched channel mask, holding each
// enabled channel for a programmable dwell, single-pass or continuous.
import dec_scan_pkg::*;

module dec_scan_ctrl #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [N_CH-1:0]    ch_en,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_vld,
   output logic               busy,
   output logic               pass_done
);
   localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

   state_t             state;
   logic [N_CH-1:0]    snap_en;
   logic               snap_mode;
   logic [DWELL_W-1:0] snap_d;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] d_eff;
   logic [N_CH-1:0]    mask;
   logic [SEL_W-1:0]   nxt;
   logic [SEL_W-1:0]   low;
   logic [SEL_W-1:0]   high;
   logic               last;

   assign d_eff = (dwell == '0) ? ONE : dwell;

   // In IDLE the live mask picks the first channel; in SCAN the snapshot.
   assign mask = (state == IDLE) ? ch_en : snap_en;

   next_ch_find u_find (
      .cur  (sel),
      .mask (mask),
      .nxt  (nxt),
      .low  (low),
      .high (high)
   );

   assign last      = (state == SCAN) && (cnt == '0) && (sel == high);
   // A stop in the final cycle of a pass swallows the pulse.
   assign pass_done = last && !stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         sel_vld   <= 1'b0;
         busy      <= 1'b0;
         snap_en   <= '0;
         snap_mode <= 1'b0;
         snap_d    <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !stop && (ch_en != '0)) begin
                  snap_en   <= ch_en;
                  snap_mode <= mode;
                  snap_d    <= d_eff;
                  sel       <= low;
                  cnt       <= d_eff - ONE;
                  sel_vld   <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (stop || (last && !snap_mode)) begin
                  state   <= IDLE;
                  sel     <= '0;
                  sel_vld <= 1'b0;
                  busy    <= 1'b0;
               end else if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else begin
                  cnt <= snap_d - ONE;
                  sel <= last ? low : nxt;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: a pass-list model predicts every
// cycle's outputs and a negedge monitor compares them.
module tb_dec_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  ch_en = '0;
   logic [15:0] dwell = '0;
   logic [2:0]  sel;
   logic        sel_vld;
   logic        busy;
   logic        pass_done;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [2:0] sel;
      logic       pd;
   } step_t;

   typedef struct {
      logic [2:0] sel;
      logic       vld;
      logic       busy;
      logic       pd;
   } obs_t;

   step_t plan[$];
   obs_t  exp_q[$];
   logic [7:0] m_en;
   logic       m_mode;
   int         m_d;

   dec_scan_ctrl #(.DWELL_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .ch_en     (ch_en),
      .dwell     (dwell),
      .sel       (sel),
      .sel_vld   (sel_vld),
      .busy      (busy),
      .pass_done (pass_done)
   );

   always #5 clk = ~clk;

   // One pass = every enabled channel, ascending, each D cycles long.
   task automatic fill();
      step_t s;
      for (int i = 0; i < 8; i++)
         if (m_en[i])
            for (int j = 0; j < m_d; j++) begin
               s.sel = 3'(i);
               s.pd  = 1'b0;
               plan.push_back(s);
            end
      plan[plan.size()-1].pd = 1'b1;
   endtask

   task automatic cyc(input logic st, input logic sp, input logic md,
                      input logic [7:0] en, input logic [15:0] dw);
      obs_t  e;
      step_t s;
      @(posedge clk);
      #1;
      start = st;
      stop  = sp;
      mode  = md;
      ch_en = en;
      dwell = dw;
      if (plan.size() > 0) begin
         s = plan[0];
         e = '{s.sel, 1'b1, 1'b1, s.pd && !sp};
         if (sp) begin
            plan.delete();
         end else begin
            s = plan.pop_front();
            if (plan.size() == 0 && m_mode) fill();
         end
      end else begin
         e = '{3'd0, 1'b0, 1'b0, 1'b0};
         if (st && !sp && en != 8'h00) begin
            m_en   = en;
            m_mode = md;
            m_d    = (dw == 16'd0) ? 1 : int'(dw);
            fill();
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
   endtask

   task automatic check_zero(input string name);
      total++;
      if ({sel, sel_vld, busy, pass_done} !== 6'd0) begin
         bad++;
         $display("FAIL %s: got sel=%0d vld=%b busy=%b pd=%b want all 0",
                  name, sel, sel_vld, busy, pass_done);
      end
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic pulse_rst();
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      plan.delete();
      #4 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      obs_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (sel !== e.sel || sel_vld !== e.vld || busy !== e.busy ||
             pass_done !== e.pd) begin
            bad++;
            $display("FAIL cycle @%0t: got sel=%0d vld=%b busy=%b pd=%b want sel=%0d vld=%b busy=%b pd=%b",
                     $time, sel, sel_vld, busy, pass_done,
                     e.sel, e.vld, e.busy, e.pd);
         end
      end
   end

   initial begin
      #2 check_zero("reset_state");
      #11 rst = 1'b0;

      cyc(1'b1, 1'b0, 1'b0, 8'hFF, 16'd1);
      idle(10);

      cyc(1'b1, 1'b0, 1'b0, 8'b0010_0100, 16'd3);
      idle(8);
      cyc(1'b1, 1'b0, 1'b0, 8'b0010_0100, 16'd0);
      idle(4);

      cyc(1'b1, 1'b0, 1'b1, 8'b1000_0001, 16'd2);
      idle(6);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 8'h02, 16'd7);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
      idle(2);

      cyc(1'b1, 1'b0, 1'b0, 8'b0010_0100, 16'd1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
      idle(2);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd1);
      idle(2);

      cyc(1'b1, 1'b1, 1'b1, 8'hFF, 16'd1);
      idle(2);

      cyc(1'b1, 1'b0, 1'b0, 8'b0101_0000, 16'd5);
      idle(2);
      pulse_rst();
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 8'b0101_0000, 16'd5);
      idle(12);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_rst();
         end else begin
            logic [7:0] en;
            en = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            cyc($urandom_range(0, 7) == 0,
                $urandom_range(0, 24) == 0,
                1'($urandom),
                en,
                16'($urandom_range(0, 4)));
         end
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
      idle(3);

      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
